// File: rtl/pulse_decoder_pkg.sv
// Shared types and helpers for the pulse decoder: FSM states, stats width,
// and the event-width calculation derived from MAX_WIDTH.
package pulse_decoder_pkg;

   typedef enum logic [1:0] {
      PD_WAIT_LOW = 2'd0,
      PD_IDLE     = 2'd1,
      PD_MEASURE  = 2'd2,
      PD_STUCK    = 2'd3
   } pd_state_t;

   localparam int STAT_W = 32;

   // Bits needed to hold every count from 0 up to max_width inclusive.
   function automatic int width_for(input int max_width);
      return $clog2(max_width + 1);
   endfunction

endpackage

// File: rtl/pulse_event_fifo.sv
// Small synchronous event queue. It accepts a push into a full queue when a
// pop happens in the same cycle. Its flags are derived from the element count.
module pulse_event_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_push_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;
   logic              w_pop;
   logic              w_push;

   assign o_valid = (r_count != '0);
   assign o_full  = (r_count == FULL_CNT);
   assign o_data  = r_mem[r_rd_ptr];
   assign w_pop   = i_pop && o_valid;
   assign w_push  = i_push && (!o_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/pulse_decoder.sv
// Measures stretched pulses and queues one width event per valid pulse.
// Optional saturating statistics counters are enabled by PULSE_DECODER_STATS_EN.
module pulse_decoder
   import pulse_decoder_pkg::*;
#(
   parameter int MIN_WIDTH  = 1,
   parameter int MAX_WIDTH  = 255,
   parameter int FIFO_DEPTH = 4,
   localparam int W = width_for(MAX_WIDTH)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         pulse_in,
   output logic         evt_valid,
   input  logic         evt_ready,
   output logic [W-1:0] evt_width,
   output logic         evt_drop,
   output logic         stuck
`ifdef PULSE_DECODER_STATS_EN
   ,
   output logic [STAT_W-1:0] stat_accepted,
   output logic [STAT_W-1:0] stat_glitch,
   output logic [STAT_W-1:0] stat_dropped,
   output logic [STAT_W-1:0] stat_stuck
`endif
);

   localparam logic [W-1:0] MIN_CNT = W'(MIN_WIDTH);
   localparam logic [W-1:0] MAX_CNT = W'(MAX_WIDTH);

   pd_state_t    r_state;
   logic         r_pulse_q;
   logic         r_primed;
   logic [W-1:0] r_cnt;
   logic         r_stuck;
   logic         r_drop;
   logic         w_push;
   logic         w_full;
   logic         w_drop;

   assign w_push   = (r_state == PD_MEASURE) && !r_pulse_q && (r_cnt >= MIN_CNT);
   assign w_drop   = w_push && w_full && !evt_ready;
   assign stuck    = r_stuck;
   assign evt_drop = r_drop;

   // r_primed keeps WAIT_LOW from trusting the reset value of r_pulse_q, so a
   // line held high across reset is only released after a real low sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= PD_WAIT_LOW;
         r_pulse_q <= 1'b0;
         r_primed  <= 1'b0;
         r_cnt     <= '0;
         r_stuck   <= 1'b0;
         r_drop    <= 1'b0;
      end else begin
         r_pulse_q <= pulse_in;
         r_primed  <= 1'b1;
         r_drop    <= w_drop;
         case (r_state)
            PD_WAIT_LOW: begin
               if (r_primed && !r_pulse_q) begin
                  r_state <= PD_IDLE;
               end
            end
            PD_IDLE: begin
               if (r_pulse_q) begin
                  r_cnt   <= W'(1);
                  r_state <= PD_MEASURE;
               end
            end
            PD_MEASURE: begin
               if (r_pulse_q) begin
                  if (r_cnt == MAX_CNT) begin
                     r_state <= PD_STUCK;
                     r_stuck <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + W'(1);
                  end
               end else begin
                  r_state <= PD_IDLE;
               end
            end
            PD_STUCK: begin
               if (!r_pulse_q) begin
                  r_state <= PD_IDLE;
                  r_stuck <= 1'b0;
               end
            end
            default: begin
               r_state <= PD_WAIT_LOW;
               r_stuck <= 1'b0;
            end
         endcase
      end
   end

   pulse_event_fifo #(
      .DATA_W (W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push),
      .i_push_data (r_cnt),
      .i_pop       (evt_ready),
      .o_data      (evt_width),
      .o_valid     (evt_valid),
      .o_full      (w_full)
   );

`ifdef PULSE_DECODER_STATS_EN
   logic [3:0]              w_stat_inc;
   logic [3:0][STAT_W-1:0]  w_stat;

   assign w_stat_inc[0] = w_push;
   assign w_stat_inc[1] = (r_state == PD_MEASURE) && !r_pulse_q && (r_cnt < MIN_CNT);
   assign w_stat_inc[2] = w_drop;
   assign w_stat_inc[3] = (r_state == PD_MEASURE) && r_pulse_q && (r_cnt == MAX_CNT);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_stat
         logic [STAT_W-1:0] r_stat;
         always_ff @(posedge clk) begin
            if (reset) begin
               r_stat <= '0;
            end else if (w_stat_inc[gi] && (r_stat != '1)) begin
               r_stat <= r_stat + STAT_W'(1);
            end
         end
         assign w_stat[gi] = r_stat;
      end
   endgenerate

   assign stat_accepted = w_stat[0];
   assign stat_glitch   = w_stat[1];
   assign stat_dropped  = w_stat[2];
   assign stat_stuck    = w_stat[3];
`endif

endmodule

// File: tb/tb_pulse_decoder.sv
// Scoreboard bench for pulse_decoder with MIN_WIDTH=2, MAX_WIDTH=8, FIFO_DEPTH=2.
// Stimulus pushes expected widths; a negedge monitor pops and compares on each accepted event.
module tb_pulse_decoder;

   localparam int MIN_W = 2;
   localparam int MAX_W = 8;
   localparam int DEPTH = 2;
   localparam int W     = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         pulse_in;
   logic         evt_ready;
   logic         evt_valid;
   logic [W-1:0] evt_width;
   logic         evt_drop;
   logic         stuck;
`ifdef PULSE_DECODER_STATS_EN
   logic [31:0]  stat_accepted;
   logic [31:0]  stat_glitch;
   logic [31:0]  stat_dropped;
   logic [31:0]  stat_stuck;
`endif

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   int drop_cnt = 0;
   int pop_cnt = 0;

   pulse_decoder #(
      .MIN_WIDTH  (MIN_W),
      .MAX_WIDTH  (MAX_W),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pulse_in  (pulse_in),
      .evt_valid (evt_valid),
      .evt_ready (evt_ready),
      .evt_width (evt_width),
      .evt_drop  (evt_drop),
      .stuck     (stuck)
`ifdef PULSE_DECODER_STATS_EN
      ,
      .stat_accepted (stat_accepted),
      .stat_glitch   (stat_glitch),
      .stat_dropped  (stat_dropped),
      .stat_stuck    (stat_stuck)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // High for n cycles, then low; returns one cycle after the fall.
   task automatic pulse(input int n);
      pulse_in = 1'b1;
      repeat (n) tick();
      pulse_in = 1'b0;
      tick();
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (evt_drop) begin
            drop_cnt++;
            $display("drop strobe at %0t", $time);
         end
         if (evt_valid && evt_ready) begin
            pop_cnt++;
            $display("event width=%0d at %0t", evt_width, $time);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: got width %0d, expected no event", evt_width);
            end else begin
               check("evt_width", int'(evt_width), exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      reset     = 1'b1;
      pulse_in  = 1'b0;
      evt_ready = 1'b1;
      repeat (3) tick();
      check("rst_valid", int'(evt_valid), 0);
      check("rst_stuck", int'(stuck), 0);
      check("rst_drop", int'(evt_drop), 0);
`ifdef PULSE_DECODER_STATS_EN
      check("rst_stat_acc", int'(stat_accepted), 0);
`endif
      reset = 1'b0;
      repeat (3) tick();

      // 1: single 5-cycle pulse, event exactly at fall+2 for one cycle
      exp_q.push_back(5);
      pulse(5);
      check("t1_valid_c1", int'(evt_valid), 0);
      tick();
      check("t1_valid_c2", int'(evt_valid), 1);
      check("t1_width", int'(evt_width), 5);
      tick();
      check("t1_valid_c3", int'(evt_valid), 0);
      repeat (3) tick();

      // 2: glitch
      pulse(1);
      repeat (4) tick();
      check("t2_valid", int'(evt_valid), 0);
`ifdef PULSE_DECODER_STATS_EN
      check("t2_stat_glitch", int'(stat_glitch), 1);
`endif

      // 3: max width accepted, then one more cycle goes stuck
      exp_q.push_back(8);
      pulse(8);
      repeat (4) tick();
      pulse_in = 1'b1;
      repeat (9) tick();
      pulse_in = 1'b0;
      check("t3_stuck_c9", int'(stuck), 0);
      tick();
      check("t3_stuck_c10", int'(stuck), 1);
      tick();
      check("t3_stuck_c11", int'(stuck), 0);
      repeat (4) tick();
      check("t3_valid", int'(evt_valid), 0);
`ifdef PULSE_DECODER_STATS_EN
      check("t3_stat_stuck", int'(stat_stuck), 1);
      check("t3_stat_acc", int'(stat_accepted), 2);
`endif

      // 4: queue overflow with consumer stalled
      evt_ready = 1'b0;
      exp_q.push_back(3);
      exp_q.push_back(4);
      pulse(3);
      tick();
      pulse(4);
      tick();
      check("t4_drop_before", drop_cnt, 0);
      pulse(5);
      repeat (3) tick();
      check("t4_drop_after", drop_cnt, 1);
      check("t4_head_valid", int'(evt_valid), 1);
      check("t4_head_width", int'(evt_width), 3);
      evt_ready = 1'b1;
      repeat (4) tick();
      check("t4_drained", int'(evt_valid), 0);
      check("t4_sb_empty", exp_q.size(), 0);
`ifdef PULSE_DECODER_STATS_EN
      check("t4_stat_drop", int'(stat_dropped), 1);
      check("t4_stat_acc", int'(stat_accepted), 5);
`endif

      // 5: queued event flushed by reset; line high through reset is ignored
      evt_ready = 1'b0;
      pulse(3);
      tick();
      check("t5_queued", int'(evt_valid), 1);
      pulse_in = 1'b1;
      tick();
      reset = 1'b1;
      repeat (3) tick();
      check("t5_rst_valid", int'(evt_valid), 0);
      check("t5_rst_stuck", int'(stuck), 0);
`ifdef PULSE_DECODER_STATS_EN
      check("t5_rst_stat_acc", int'(stat_accepted), 0);
`endif
      reset = 1'b0;
      repeat (3) tick();
      pulse_in  = 1'b0;
      evt_ready = 1'b1;
      repeat (5) tick();
      check("t5_no_event", int'(evt_valid), 0);
      exp_q.push_back(4);
      pulse(4);
      repeat (3) tick();
      check("t5_sb_empty", exp_q.size(), 0);

      // 6: back-to-back pulses with a one-cycle gap
      begin
         int d0;
         d0 = drop_cnt;
         exp_q.push_back(2);
         exp_q.push_back(8);
         pulse_in = 1'b1;
         repeat (2) tick();
         pulse_in = 1'b0;
         tick();
         pulse_in = 1'b1;
         repeat (8) tick();
         pulse_in = 1'b0;
         repeat (5) tick();
         check("t6_no_drop", drop_cnt, d0);
         check("t6_sb_empty", exp_q.size(), 0);
      end

      check("total_events", pop_cnt, 7);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pulse_decoder.md
# pulse_decoder

Receive-side counterpart of the pulse generator. Measures the length of stretched pulses on a single-bit control line and converts each valid pulse back into one event carrying the measured width. Events are delivered over a valid/ready queue. Too-short pulses are rejected as glitches, and pulses longer than the maximum are flagged as a stuck line. It sits at the input of control paths fed by pulse-stretched status lines.

## Interface
- `MIN_WIDTH`, 1: shortest accepted pulse in cycles; shorter pulses are glitches. Must satisfy 1 ≤ MIN_WIDTH ≤ MAX_WIDTH.
- `MAX_WIDTH`, 255: longest accepted pulse in cycles; longer pulses mean the line is stuck.
- `FIFO_DEPTH`, 4: event queue depth; power of two, ≥ 2.
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-high reset.
- `pulse_in`  in  1  stretched pulse line, synchronous to `clk`.
- `evt_valid`  out  1  queue head valid.
- `evt_ready`  in  1  consumer accepts the head.
- `evt_width`  out  W=$clog2(MAX_WIDTH+1)  width of the head event, in cycles.
- `evt_drop`  out  1  one-cycle strobe: an accepted pulse was lost because the queue was full.
- `stuck`  out  1  level: current pulse has exceeded MAX_WIDTH.

## Operation
- `pulse_in` is registered once into `pulse_q`. All decisions use `pulse_q`.
- FSM states: WAIT_LOW (reset state), IDLE, MEASURE, STUCK.
  - WAIT_LOW: when `pulse_q`=0, go to IDLE. A line that is already high out of reset is never measured.
  - IDLE: when `pulse_q`=1, set cnt←1 and go to MEASURE.
  - MEASURE, `pulse_q`=1:
    - if cnt==MAX_WIDTH, go to STUCK;
    - otherwise cnt←cnt+1.
  - MEASURE, `pulse_q`=0:
    - if cnt≥MIN_WIDTH, push cnt to the queue;
    - otherwise discard the pulse as a glitch;
    - in both cases go to IDLE.
  - STUCK: when `pulse_q`=0, go to IDLE. No event is pushed.
- cnt is W bits wide and never wraps; its maximum value is MAX_WIDTH.
- Queue behaviour:
  - Pop on `evt_valid && evt_ready`.
  - A push into a full queue is allowed in the same cycle as a pop.
  - A push into a full queue with no pop is dropped, and `evt_drop` pulses for 1 cycle.
  - FIFO order is always preserved.
- `evt_width` is stable while `evt_valid && !evt_ready`.
- `stuck`=1 exactly while the FSM is in STUCK.

## Timing
- Reset values: `evt_valid`=0, `evt_drop`=0, `stuck`=0, `pulse_q`=0, FSM=WAIT_LOW, queue empty, cnt=0.
- Event latency: if `pulse_in` is high for N cycles and first low in cycle c, then `evt_valid` is asserted in cycle c+2 (assuming the queue was empty), with `evt_width`=N.
- `stuck` latency: with `pulse_in` high from cycle c0, `stuck` is asserted in cycle c0+MAX_WIDTH+2. It deasserts 2 cycles after `pulse_in` first goes low.
- Back-to-back pulses separated by a single low cycle are each measured correctly.
- Throughput: one event per 2 cycles on the input side; one pop per cycle on the output side.
- Reset mid-operation: reset wins in the same cycle. The queue is flushed, and any pulse in flight is neither counted nor reported.

## Configuration
- `PULSE_DECODER_STATS_EN` defined: adds four output ports, each 32 bits, saturating (no wrap), cleared by reset, incrementing one cycle after the event:
  - `stat_accepted`: pushes, including dropped ones;
  - `stat_glitch`;
  - `stat_dropped`;
  - `stat_stuck`: entries into STUCK.
- `PULSE_DECODER_STATS_EN` undefined: the four ports and the counters do not exist. All other behaviour is identical.

## Structure
- `pulse_decoder_pkg` holds:
  - the FSM state enum (`pd_state_t`);
  - the stats counter width constant (32);
  - the width function used to compute W from MAX_WIDTH.
- One sub-module, `pulse_event_fifo`:
  - synchronous FIFO, parameterised by data width and depth;
  - outputs a full flag and a valid flag driven from its element count;
  - supports simultaneous push and pop when full.

## Test plan
All scenarios use MIN_WIDTH=2, MAX_WIDTH=8, FIFO_DEPTH=2.
1. `pulse_in` high for 5 cycles, `evt_ready`=1 → exactly one event with `evt_width`=5; `evt_valid` is high for 1 cycle, 2 cycles after `pulse_in` falls.
2. `pulse_in` high for 1 cycle → no event; `stat_glitch`=1 (macro on).
3. `pulse_in` high for 8 cycles, then for 9 cycles → event with width 8; then `stuck` high from cycle c0+10 until 2 cycles after the fall, with no second event.
4. `evt_ready`=0, pulses of width 3, 4, 5 → `evt_drop` pulses once, for the width-5 pulse. Raising `evt_ready` then yields 3, then 4, then `evt_valid`=0.
5. `pulse_in` high through reset and for 3 cycles after → no event. A following 4-cycle pulse → event with width 4.
6. Pulses of width 2 and 8 with a 1-cycle gap, `evt_ready`=1 → events 2 and 8, in order, with no drop.
